// File: rtl/seq_mag_compare.sv
// seq_mag_compare: multi-cycle cascadable magnitude comparator, MSB slice first.
// Define SIGNED_CMP_EN to add the SGN port for two's-complement compares.
module seq_mag_compare #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             ALBI,
   input  logic             AEBI,
   input  logic             AGBI,
`ifdef SIGNED_CMP_EN
   input  logic             SGN,
`endif
   output logic             busy,
   output logic             done,
   output logic             ALBO,
   output logic             AEBO,
   output logic             AGBO
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] TOP = IW'(NCHUNK - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                       state;
   logic [NCHUNK-1:0][CHUNK-1:0] a_q;
   logic [NCHUNK-1:0][CHUNK-1:0] b_q;
   logic [2:0]                   casc_q;
   logic [IW-1:0]                idx;
   logic [CHUNK-1:0]             a_s;
   logic [CHUNK-1:0]             b_s;
`ifdef SIGNED_CMP_EN
   logic                         sgn_q;
`endif

   always_comb begin
      a_s = a_q[idx];
      b_s = b_q[idx];
`ifdef SIGNED_CMP_EN
      // flipping the sign bit maps two's-complement order onto unsigned order
      if (sgn_q && idx == TOP) begin
         a_s[CHUNK-1] = ~a_s[CHUNK-1];
         b_s[CHUNK-1] = ~b_s[CHUNK-1];
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         ALBO   <= 1'b0;
         AEBO   <= 1'b0;
         AGBO   <= 1'b0;
         idx    <= TOP;
         a_q    <= '0;
         b_q    <= '0;
         casc_q <= '0;
`ifdef SIGNED_CMP_EN
         sgn_q  <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q    <= A;
                  b_q    <= B;
                  casc_q <= {ALBI, AEBI, AGBI};
`ifdef SIGNED_CMP_EN
                  sgn_q  <= SGN;
`endif
                  {ALBO, AEBO, AGBO} <= 3'b000;
                  busy   <= 1'b1;
                  idx    <= TOP;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (a_s > b_s)
                  {ALBO, AEBO, AGBO} <= 3'b001;
               else if (a_s < b_s)
                  {ALBO, AEBO, AGBO} <= 3'b100;
               else if (idx == '0)
                  {ALBO, AEBO, AGBO} <= casc_q;

               if (a_s != b_s || idx == '0) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  idx <= idx - IW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mag_compare.sv
// tb_seq_mag_compare: scoreboard bench for seq_mag_compare (WIDTH=32, CHUNK=8).
// Build with SIGNED_CMP_EN defined to exercise the signed path.
module tb_seq_mag_compare;

   typedef struct {
      logic [2:0] res;
      int         lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        ALBI = 1'b0;
   logic        AEBI = 1'b0;
   logic        AGBI = 1'b0;
   logic        sgn = 1'b0;
   logic        busy, done, ALBO, AEBO, AGBO;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   seq_mag_compare #(.WIDTH(32), .CHUNK(8)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .A     (A),
      .B     (B),
      .ALBI  (ALBI),
      .AEBI  (AEBI),
      .AGBI  (AGBI),
`ifdef SIGNED_CMP_EN
      .SGN   (sgn),
`endif
      .busy  (busy),
      .done  (done),
      .ALBO  (ALBO),
      .AEBO  (AEBO),
      .AGBO  (AGBO)
   );

   function automatic exp_t model(logic [31:0] a, logic [31:0] b,
                                  logic [2:0] c, logic s);
      exp_t e;
      logic [7:0] x, y;
      e.res = c;
      e.lat = 4;
      for (int i = 3; i >= 0; i--) begin
         x = a[i*8 +: 8];
         y = b[i*8 +: 8];
         if (s && i == 3) begin
            x[7] = ~x[7];
            y[7] = ~y[7];
         end
         if (x != y) begin
            e.res = (x > y) ? 3'b001 : 3'b100;
            e.lat = 4 - i;
            return e;
         end
      end
      return e;
   endfunction

   task automatic push(logic [2:0] r, int l);
      exp_t e;
      e.res = r;
      e.lat = l;
      q.push_back(e);
   endtask

   task automatic issue(logic [31:0] a, logic [31:0] b,
                        logic [2:0] c, logic s);
      A = a;
      B = b;
      {ALBI, AEBI, AGBI} = c;
      sgn = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_busy got %b want 0", busy);
      end
      n_cmp++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_done got %b want 0", done);
      end
      n_cmp++;
      if ({ALBO, AEBO, AGBO} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_out got %b want 000", {ALBO, AEBO, AGBO});
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic;
      exp_t e;
      int   cyc;
      push(3'b001, 2);
      issue(32'h12345678, 32'h12335678, 3'b010, 1'b0);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL basic_busy got %b want 1", busy);
      end
      wait_done(cyc);
      e = q.pop_front();
      n_cmp++;
      if (cyc !== e.lat) begin
         n_err++;
         $display("FAIL basic_lat got %0d want %0d", cyc, e.lat);
      end
      n_cmp++;
      if ({ALBO, AEBO, AGBO} !== e.res) begin
         n_err++;
         $display("FAIL basic_out got %b want %b", {ALBO, AEBO, AGBO}, e.res);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL basic_busy_end got %b want 0", busy);
      end
   endtask

   task automatic test_hold;
      A = 32'hFFFFFFFF;
      B = 32'h0;
      {ALBI, AEBI, AGBI} = 3'b111;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL hold_done got %b want 0", done);
      end
      n_cmp++;
      if ({ALBO, AEBO, AGBO} !== 3'b001) begin
         n_err++;
         $display("FAIL hold_out got %b want 001", {ALBO, AEBO, AGBO});
      end
   endtask

   task automatic test_cascade;
      exp_t e;
      int   cyc;
      logic [2:0] casc [3];
      casc[0] = 3'b010;
      casc[1] = 3'b100;
      casc[2] = 3'b111;
      for (int i = 0; i < 3; i++) begin
         push(casc[i], 4);
         issue(32'hDEADBEEF, 32'hDEADBEEF, casc[i], 1'b0);
         wait_done(cyc);
         e = q.pop_front();
         n_cmp++;
         if (cyc !== e.lat) begin
            n_err++;
            $display("FAIL casc%0d_lat got %0d want %0d", i, cyc, e.lat);
         end
         n_cmp++;
         if ({ALBO, AEBO, AGBO} !== e.res) begin
            n_err++;
            $display("FAIL casc%0d_out got %b want %b", i,
                     {ALBO, AEBO, AGBO}, e.res);
         end
      end
   endtask

   task automatic test_ignore_busy;
      exp_t e;
      push(3'b100, 1);
      issue(32'h01000000, 32'h02000000, 3'b010, 1'b0);
      A = 32'hFF000000;
      B = 32'h00000000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e = q.pop_front();
      n_cmp++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL ign_done got %b want 1", done);
      end
      n_cmp++;
      if ({ALBO, AEBO, AGBO} !== e.res) begin
         n_err++;
         $display("FAIL ign_out got %b want %b", {ALBO, AEBO, AGBO}, e.res);
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_err++;
         $display("FAIL ign_quiet got %b want 00", {busy, done});
      end
   endtask

   task automatic test_reset_mid;
      exp_t e;
      int   cyc;
      issue(32'h0, 32'h0, 3'b010, 1'b0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, ALBO, AEBO, AGBO} !== 5'b00000) begin
         n_err++;
         $display("FAIL rstmid got %b want 00000",
                  {busy, done, ALBO, AEBO, AGBO});
      end
      @(negedge clk);
      reset = 1'b0;
      push(3'b001, 4);
      issue(32'd5, 32'd3, 3'b010, 1'b0);
      wait_done(cyc);
      e = q.pop_front();
      n_cmp++;
      if (cyc !== e.lat) begin
         n_err++;
         $display("FAIL rstmid_lat got %0d want %0d", cyc, e.lat);
      end
      n_cmp++;
      if ({ALBO, AEBO, AGBO} !== e.res) begin
         n_err++;
         $display("FAIL rstmid_out got %b want %b", {ALBO, AEBO, AGBO}, e.res);
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   cyc;
      push(3'b001, 1);
      issue(32'hAA000000, 32'h55000000, 3'b010, 1'b0);
      wait_done(cyc);
      e = q.pop_front();
      n_cmp++;
      if (cyc !== e.lat || {ALBO, AEBO, AGBO} !== e.res) begin
         n_err++;
         $display("FAIL b2b_first got %0d/%b want %0d/%b", cyc,
                  {ALBO, AEBO, AGBO}, e.lat, e.res);
      end
      push(3'b100, 4);
      issue(32'h00000010, 32'h00000020, 3'b001, 1'b0);
      n_cmp++;
      if ({busy, done} !== 2'b10) begin
         n_err++;
         $display("FAIL b2b_accept got %b want 10", {busy, done});
      end
      wait_done(cyc);
      e = q.pop_front();
      n_cmp++;
      if (cyc !== e.lat || {ALBO, AEBO, AGBO} !== e.res) begin
         n_err++;
         $display("FAIL b2b_second got %0d/%b want %0d/%b", cyc,
                  {ALBO, AEBO, AGBO}, e.lat, e.res);
      end
   endtask

   task automatic test_random;
      exp_t e;
      int   cyc;
      logic [31:0] a, b;
      logic [2:0]  c;
      logic        s;
      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         b = a;
         if (i % 4 != 0)
            b[($urandom_range(0, 3))*8 +: 8] = 8'($urandom);
         c = 3'($urandom);
         s = 1'b0;
`ifdef SIGNED_CMP_EN
         s = 1'($urandom);
`endif
         q.push_back(model(a, b, c, s));
         issue(a, b, c, s);
         wait_done(cyc);
         e = q.pop_front();
         n_cmp++;
         if (cyc !== e.lat || {ALBO, AEBO, AGBO} !== e.res) begin
            n_err++;
            $display("FAIL rand%0d got %0d/%b want %0d/%b a=%h b=%h", i, cyc,
                     {ALBO, AEBO, AGBO}, e.lat, e.res, a, b);
         end
      end
   endtask

`ifdef SIGNED_CMP_EN
   task automatic test_signed;
      exp_t e;
      int   cyc;
      push(3'b100, 1);
      push(3'b001, 1);
      for (int i = 0; i < 2; i++) begin
         issue(32'hFFFFFFFF, 32'h00000001, 3'b010, (i == 0));
         wait_done(cyc);
         e = q.pop_front();
         n_cmp++;
         if (cyc !== e.lat || {ALBO, AEBO, AGBO} !== e.res) begin
            n_err++;
            $display("FAIL signed%0d got %0d/%b want %0d/%b", i, cyc,
                     {ALBO, AEBO, AGBO}, e.lat, e.res);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_cascade();
      test_ignore_busy();
      test_reset_mid();
      test_back_to_back();
`ifdef SIGNED_CMP_EN
      test_signed();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
